load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the core's MEM stage.
- Drives the byte-addressed memory port (address, data_write, write_enable, data_read), where write_enable encodings are 0001 = byte, 0011 = half, 1111 = word.
- Performs RV32I size decoding, misalignment checking and load sign/zero extension.
- Returns the result over a valid/ready response handshake.

Parameters:
- LATENCY, 1, cycles the memory port is held per access (≥1); read data sampled and write committed on the last of these cycles.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits used)
- resp_valid  out  1  response available
- resp_ready  in  1  core consumes response
- resp_data  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  misaligned or illegal funct3; no memory access made
- mem_address  out  32  to memory address
- mem_data_write  out  32  to memory data_write
- mem_write_enable  out  4  to memory write_enable
- mem_data_read  in  32  from memory data_read (combinational, little-endian word at mem_address)

Behaviour:
- Reset (async, immediate) values:
  - state IDLE; req_ready 1; resp_valid 0; resp_data 0; resp_fault 0.
  - mem_address 0, mem_data_write 0, mem_write_enable 0.
  - Latency counter 0; request registers 0.
- FSM states: IDLE, ACCESS, RESP. req_ready = (state==IDLE).
- IDLE:
  - On req_valid, capture is_store, funct3, addr, wdata.
  - Legality check on the captured request:
    - Fault if store funct3 ∉ {000,001,010}.
    - Fault if load funct3 ∉ {000,001,010,100,101}.
    - Fault if half with addr[0]≠0, or word with addr[1:0]≠0.
  - Legal request: go to ACCESS, counter = LATENCY-1.
  - Faulting request: go directly to RESP with resp_fault=1, resp_data=0; no memory cycle.
- ACCESS:
  - mem_address = captured addr, unmodified (no alignment masking).
  - Store:
    - mem_data_write = wdata with unused upper bits zeroed: byte keeps [7:0], half keeps [15:0].
    - mem_write_enable = 0001/0011/1111 per size, asserted ONLY in the final ACCESS cycle (counter==0), so exactly one write is committed per store.
  - Load: mem_write_enable = 0 throughout.
  - Counter decrements each cycle.
  - At the counter==0 edge:
    - Load: resp_data <= extend(mem_data_read). B sign-extends [7:0], H sign-extends [15:0], W passes through, BU/HU zero-extend.
    - Store: resp_data <= 0.
    - Go to RESP.
- Memory outputs are 0 in IDLE and RESP (combinational from state; no glitch-free guarantee needed beyond registered state).
- RESP:
  - resp_valid=1; resp_data and resp_fault held stable until resp_valid&&resp_ready.
  - On that handshake: go to IDLE and clear resp_fault/resp_data.
  - No new request accepted in the same cycle; minimum back-to-back spacing is LATENCY+2 cycles.
- Latency: req accept edge → resp_valid high after LATENCY+1 edges (legal), 1 edge (fault).
- Reset mid-ACCESS: write_enable drops immediately; a store not yet at its committing edge is not written.
- req_valid while not IDLE is ignored; request signals are don't-care outside IDLE.
- Simultaneous resp handshake and new req_valid: new req is taken only on the following IDLE cycle.

Test Plan:
- LATENCY=1, SW addr 0x100 wdata 0xDEADBEEF → one cycle with mem_address=0x100, mem_write_enable=1111, mem_data_write=0xDEADBEEF; resp_valid next cycle, resp_fault=0, resp_data=0.
- SB addr 0x103 wdata 0x123456AB → mem_write_enable=0001, mem_data_write=0x000000AB for exactly one cycle; then LBU 0x103 with mem_data_read=0x000000AB → resp_data=0x000000AB; LB same → 0xFFFFFFAB.
- LH addr 0x202 with mem_data_read=0x00008001 → resp_data=0xFFFF8001; LHU → 0x00008001.
- LW addr 0x201 and SH addr 0x301 → resp_valid one cycle after accept, resp_fault=1, mem_write_enable stays 0000, memory port never driven.
- LATENCY=3, SW 0x40: write_enable=1111 only in third ACCESS cycle; hold resp_ready=0 for 5 cycles → resp_valid/resp_data stable, req_ready=0; a second req_valid during this window is not accepted.
- Assert rst during the first ACCESS cycle of a LATENCY=3 store → all outputs reset within the cycle, no write_enable pulse observed, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, byte-addressed memory port,
// misalignment/illegal-width faulting, load extension and a valid/ready response.
module load_store_unit #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_write,
    output logic [3:0]  mem_write_enable,
    input  logic [31:0] mem_data_read
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              is_store_r, is_store_s;
    logic [2:0]        funct3_r, funct3_s;
    logic [31:0]       addr_r, addr_s;
    logic [31:0]       wdata_r, wdata_s;
    logic [31:0]       resp_data_r, resp_data_s;
    logic              resp_fault_r, resp_fault_s;

    // Illegal width for the direction, or a half/word not naturally aligned.
    function automatic logic req_fault_f(input logic is_store, input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic fault;
        case (funct3)
            3'b000:  fault = 1'b0;
            3'b001:  fault = addr_lo[0];
            3'b010:  fault = (addr_lo != 2'b00);
            3'b100:  fault = is_store;
            3'b101:  fault = is_store | addr_lo[0];
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

    function automatic logic [3:0] store_mask_f(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] store_data_f(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] data;
        case (size)
            2'b00:   data = {24'h000000, wdata[7:0]};
            2'b01:   data = {16'h0000, wdata[15:0]};
            default: data = wdata;
        endcase
        return data;
    endfunction

    function automatic logic [31:0] load_extend_f(input logic [2:0] funct3, input logic [31:0] rd);
        logic [31:0] data;
        case (funct3)
            3'b000:  data = {{24{rd[7]}}, rd[7:0]};
            3'b001:  data = {{16{rd[15]}}, rd[15:0]};
            3'b100:  data = {24'h000000, rd[7:0]};
            3'b101:  data = {16'h0000, rd[15:0]};
            default: data = rd;
        endcase
        return data;
    endfunction

    assign req_ready  = (state_r == IDLE);
    assign resp_valid = (state_r == RESP);
    assign resp_data  = resp_data_r;
    assign resp_fault = resp_fault_r;

    // Memory port is driven only while accessing; the write strobe lands on the final cycle only.
    always_comb begin
        mem_address      = 32'h0000_0000;
        mem_data_write   = 32'h0000_0000;
        mem_write_enable = 4'b0000;
        if (state_r == ACCESS) begin
            mem_address = addr_r;
            if (is_store_r) begin
                mem_data_write = store_data_f(funct3_r[1:0], wdata_r);
                if (cnt_r == {CNT_W{1'b0}}) begin
                    mem_write_enable = store_mask_f(funct3_r[1:0]);
                end else begin
                    mem_write_enable = 4'b0000;
                end
            end else begin
                mem_data_write = 32'h0000_0000;
            end
        end else begin
            mem_address = 32'h0000_0000;
        end
    end

    // Next-state and datapath update for the IDLE/ACCESS/RESP sequence.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        is_store_s   = is_store_r;
        funct3_s     = funct3_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        resp_data_s  = resp_data_r;
        resp_fault_s = resp_fault_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    is_store_s = req_is_store;
                    funct3_s   = req_funct3;
                    addr_s     = req_addr;
                    wdata_s    = req_wdata;
                    if (req_fault_f(req_is_store, req_funct3, req_addr[1:0])) begin
                        state_s      = RESP;
                        resp_fault_s = 1'b1;
                        resp_data_s  = 32'h0000_0000;
                    end else begin
                        state_s = ACCESS;
                        cnt_s   = CNT_W'(LATENCY - 1);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = RESP;
                    if (is_store_r) begin
                        resp_data_s = 32'h0000_0000;
                    end else begin
                        resp_data_s = load_extend_f(funct3_r, mem_data_read);
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_s      = IDLE;
                    resp_data_s  = 32'h0000_0000;
                    resp_fault_s = 1'b0;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            is_store_r   <= 1'b0;
            funct3_r     <= 3'b000;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            resp_data_r  <= 32'h0000_0000;
            resp_fault_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            is_store_r   <= is_store_s;
            funct3_r     <= funct3_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            resp_data_r  <= resp_data_s;
            resp_fault_r <= resp_fault_s;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: LATENCY=1 and LATENCY=3 instances, each with a byte memory,
// checked every cycle against a transaction-timeline model plus directed literal expectations.
module tb_load_store_unit;

    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_is_store [NI];
    logic [2:0]  req_funct3 [NI];
    logic [31:0] req_addr [NI];
    logic [31:0] req_wdata [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [31:0] resp_data [NI];
    logic        resp_fault [NI];
    logic [31:0] mem_address [NI];
    logic [31:0] mem_data_write [NI];
    logic [3:0]  mem_write_enable [NI];
    logic [31:0] mem_data_read [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        load_store_unit #(.LATENCY((g == 0) ? 1 : 3)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_is_store(req_is_store[g]), .req_funct3(req_funct3[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
            .resp_data(resp_data[g]), .resp_fault(resp_fault[g]),
            .mem_address(mem_address[g]), .mem_data_write(mem_data_write[g]),
            .mem_write_enable(mem_write_enable[g]), .mem_data_read(mem_data_read[g])
        );
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] init_byte(input int g, input int i);
        return 8'((i * 7) + (g * 91) + 13) ^ 8'(i >> 3);
    endfunction

    // Physical memory seen by the DUTs: byte array, little-endian word read at any address.
    logic [7:0] phys_mem [NI][1024];
    logic       mem_init_done = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int g = 0; g < NI; g++)
                for (int i = 0; i < 1024; i++) phys_mem[g][i] <= init_byte(g, i);
            mem_init_done <= 1'b1;
        end else begin
            for (int g = 0; g < NI; g++)
                for (int b = 0; b < 4; b++)
                    if (mem_write_enable[g][b])
                        phys_mem[g][10'(mem_address[g] + 32'(b))] <= mem_data_write[g][8*b +: 8];
        end
    end

    always_comb begin
        for (int g = 0; g < NI; g++) begin
            mem_data_read[g] = 32'h0;
            for (int b = 0; b < 4; b++)
                mem_data_read[g][8*b +: 8] = phys_mem[g][10'(mem_address[g] + 32'(b))];
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [NI][1024];
    int          acc_left [NI];     // memory-port cycles still to come for the current request
    bit          resp_pend [NI];
    bit          m_store [NI];
    logic [2:0]  m_f3 [NI];
    logic [31:0] m_addr [NI];
    logic [31:0] m_wdata [NI];
    logic [31:0] m_data [NI];
    bit          m_fault [NI];

    int checks = 0;
    int errors = 0;
    int we_seen [NI];
    logic [3:0]  last_we [NI];
    logic [31:0] last_wd [NI];
    logic [31:0] last_addr [NI];
    bit          port_driven [NI];

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    endfunction

    function automatic bit is_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return !legal || ((a % 32'(nbytes(f3))) != 32'd0);
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'd0:    return 32'($signed(w[7:0]));
            3'd1:    return 32'($signed(w[15:0]));
            3'd4:    return w & 32'h0000_00FF;
            3'd5:    return w & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [inst %0d] t=%0t: got %h, expected %h", name, g, $time, act, exp);
        end
    endtask

    task automatic advance(input int g);
        int nb;
        logic [31:0] rd;
        if (rst) begin
            acc_left[g] = 0;
            resp_pend[g] = 1'b0;
        end else if (acc_left[g] > 0) begin
            acc_left[g]--;
            if (acc_left[g] == 0) begin
                nb = nbytes(m_f3[g]);
                if (m_store[g]) begin
                    for (int b = 0; b < nb; b++)
                        ref_mem[g][10'(m_addr[g] + 32'(b))] = m_wdata[g][8*b +: 8];
                    m_data[g] = 32'h0;
                end else begin
                    rd = 32'h0;
                    for (int b = 0; b < 4; b++)
                        rd[8*b +: 8] = ref_mem[g][10'(m_addr[g] + 32'(b))];
                    m_data[g] = extend(m_f3[g], rd);
                end
                m_fault[g] = 1'b0;
                resp_pend[g] = 1'b1;
            end
        end else if (resp_pend[g]) begin
            if (resp_ready[g]) resp_pend[g] = 1'b0;
        end else if (req_valid[g]) begin
            m_store[g] = req_is_store[g];
            m_f3[g]    = req_funct3[g];
            m_addr[g]  = req_addr[g];
            m_wdata[g] = req_wdata[g];
            if (is_fault(m_store[g], m_f3[g], m_addr[g])) begin
                resp_pend[g] = 1'b1;
                m_fault[g]   = 1'b1;
                m_data[g]    = 32'h0;
            end else begin
                acc_left[g] = lat_of(g);
            end
        end
    endtask

    task automatic compare(input int g);
        int nb;
        logic [31:0] exp_wd;
        logic [3:0]  exp_we;
        nb = nbytes(m_f3[g]);
        exp_wd = 32'h0;
        exp_we = 4'h0;
        if (acc_left[g] > 0 && m_store[g])
            exp_wd = (nb == 4) ? m_wdata[g] : (m_wdata[g] & ((32'h1 << (8 * nb)) - 32'h1));
        if (acc_left[g] == 1 && m_store[g])
            exp_we = 4'((1 << nb) - 1);
        chk("req_ready", g, 32'(req_ready[g]), 32'(acc_left[g] == 0 && !resp_pend[g]));
        chk("resp_valid", g, 32'(resp_valid[g]), 32'(resp_pend[g]));
        chk("resp_data", g, resp_data[g], resp_pend[g] ? m_data[g] : 32'h0);
        chk("resp_fault", g, 32'(resp_fault[g]), resp_pend[g] ? 32'(m_fault[g]) : 32'h0);
        chk("mem_address", g, mem_address[g], (acc_left[g] > 0) ? m_addr[g] : 32'h0);
        chk("mem_data_write", g, mem_data_write[g], exp_wd);
        chk("mem_write_enable", g, 32'(mem_write_enable[g]), 32'(exp_we));
    endtask

    task automatic record(input int g);
        if (mem_write_enable[g] != 4'h0) begin
            we_seen[g]++;
            last_we[g]   = mem_write_enable[g];
            last_wd[g]   = mem_data_write[g];
            last_addr[g] = mem_address[g];
        end
        if (mem_address[g] != 32'h0 || mem_data_write[g] != 32'h0 || mem_write_enable[g] != 4'h0)
            port_driven[g] = 1'b1;
    endtask

    // One cycle: sample at the falling edge, update model, compare, then leave room for new inputs.
    task automatic tick();
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            advance(g);
            compare(g);
            record(g);
        end
        #1;
    endtask

    task automatic junk_req(input int g, input bit v);
        req_valid[g]    = v;
        req_is_store[g] = 1'($urandom_range(0, 1));
        req_funct3[g]   = 3'($urandom);
        req_addr[g]     = $urandom;
        req_wdata[g]    = $urandom;
    endtask

    task automatic txn(input int g, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, output logic [31:0] rdata,
                       output logic flt, output int lat, output int wes);
        int we0;
        int n;
        we0 = we_seen[g];
        port_driven[g] = 1'b0;
        req_valid[g] = 1'b1; req_is_store[g] = st; req_funct3[g] = f3;
        req_addr[g] = a; req_wdata[g] = wd;
        tick();
        req_valid[g] = 1'b0;
        n = 0;
        while (!resp_valid[g] && n < 30) begin
            junk_req(g, 1'($urandom_range(0, 1)));
            tick();
            n++;
        end
        if (!resp_valid[g]) chk("resp_timeout", g, 32'(resp_valid[g]), 32'h1);
        lat = n + 1;
        for (int h = 0; h < hold; h++) begin
            junk_req(g, 1'b1);
            tick();
        end
        rdata = resp_data[g];
        flt = resp_fault[g];
        resp_ready[g] = 1'b1;
        junk_req(g, 1'b1);
        tick();
        resp_ready[g] = 1'b0;
        req_valid[g] = 1'b0;
        tick();
        wes = we_seen[g] - we0;
    endtask

    logic [31:0] rd;
    logic        flt;
    int          lat, wes, we0;

    initial begin
        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            req_valid[g] = 1'b0; req_is_store[g] = 1'b0; req_funct3[g] = 3'd0;
            req_addr[g] = 32'h0; req_wdata[g] = 32'h0; resp_ready[g] = 1'b0;
            acc_left[g] = 0; resp_pend[g] = 1'b0; m_store[g] = 1'b0; m_f3[g] = 3'd0;
            m_addr[g] = 32'h0; m_wdata[g] = 32'h0; m_data[g] = 32'h0; m_fault[g] = 1'b0;
            we_seen[g] = 0; last_we[g] = 4'h0; last_wd[g] = 32'h0; last_addr[g] = 32'h0;
            port_driven[g] = 1'b0;
            for (int i = 0; i < 1024; i++) ref_mem[g][i] = init_byte(g, i);
        end
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // SW 0x100, LATENCY=1
        txn(0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, rd, flt, lat, wes);
        chk("sw_wes", 0, 32'(wes), 32'd1);
        chk("sw_we", 0, 32'(last_we[0]), 32'hF);
        chk("sw_addr", 0, last_addr[0], 32'h100);
        chk("sw_wdata", 0, last_wd[0], 32'hDEADBEEF);
        chk("sw_lat", 0, 32'(lat), 32'd2);
        chk("sw_resp", 0, {rd[30:0], flt}, 32'h0);

        // SB 0x103 then LBU/LB
        txn(0, 1'b1, 3'b000, 32'h103, 32'h123456AB, 1, rd, flt, lat, wes);
        chk("sb_wes", 0, 32'(wes), 32'd1);
        chk("sb_we", 0, 32'(last_we[0]), 32'h1);
        chk("sb_wdata", 0, last_wd[0], 32'h000000AB);
        txn(0, 1'b0, 3'b100, 32'h103, 32'h0, 0, rd, flt, lat, wes);
        chk("lbu", 0, rd, 32'h000000AB);
        txn(0, 1'b0, 3'b000, 32'h103, 32'h0, 0, rd, flt, lat, wes);
        chk("lb", 0, rd, 32'hFFFFFFAB);

        // LH/LHU at 0x202 with memory word 0x00008001
        txn(0, 1'b1, 3'b001, 32'h202, 32'hFFFF8001, 0, rd, flt, lat, wes);
        txn(0, 1'b1, 3'b001, 32'h204, 32'h00000000, 0, rd, flt, lat, wes);
        txn(0, 1'b0, 3'b001, 32'h202, 32'h0, 0, rd, flt, lat, wes);
        chk("lh", 0, rd, 32'hFFFF8001);
        txn(0, 1'b0, 3'b101, 32'h202, 32'h0, 2, rd, flt, lat, wes);
        chk("lhu", 0, rd, 32'h00008001);

        // Misaligned LW and SH fault without touching memory
        txn(0, 1'b0, 3'b010, 32'h201, 32'h0, 0, rd, flt, lat, wes);
        chk("lw_mis_fault", 0, 32'(flt), 32'h1);
        chk("lw_mis_lat", 0, 32'(lat), 32'd1);
        chk("lw_mis_port", 0, 32'(port_driven[0]), 32'h0);
        txn(0, 1'b1, 3'b001, 32'h301, 32'h5555, 0, rd, flt, lat, wes);
        chk("sh_mis_fault", 0, 32'(flt), 32'h1);
        chk("sh_mis_data", 0, rd, 32'h0);
        chk("sh_mis_wes", 0, 32'(wes), 32'd0);
        chk("sh_mis_port", 0, 32'(port_driven[0]), 32'h0);

        // LATENCY=3 store with a long response stall and ignored requests
        txn(1, 1'b1, 3'b010, 32'h40, 32'h0BADF00D, 5, rd, flt, lat, wes);
        chk("sw3_wes", 1, 32'(wes), 32'd1);
        chk("sw3_lat", 1, 32'(lat), 32'd4);
        chk("sw3_addr", 1, last_addr[1], 32'h40);

        // Reset in the first ACCESS cycle of a LATENCY=3 store
        we0 = we_seen[1];
        req_valid[1] = 1'b1; req_is_store[1] = 1'b1; req_funct3[1] = 3'b010;
        req_addr[1] = 32'h80; req_wdata[1] = 32'hCAFEF00D;
        tick();
        req_valid[1] = 1'b0;
        chk("rst_pre_addr", 1, mem_address[1], 32'h80);
        rst = 1'b1;
        #1;
        chk("rst_we", 1, 32'(mem_write_enable[1]), 32'h0);
        chk("rst_addr", 1, mem_address[1], 32'h0);
        chk("rst_wdata", 1, mem_data_write[1], 32'h0);
        chk("rst_ready", 1, 32'(req_ready[1]), 32'h1);
        chk("rst_rvalid", 1, 32'(resp_valid[1]), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_no_write", 1, 32'(we_seen[1] - we0), 32'd0);
        txn(1, 1'b0, 3'b010, 32'h80, 32'h0, 0, rd, flt, lat, wes);
        chk("rst_mem_kept", 1, rd, {init_byte(1, 16'h83), init_byte(1, 16'h82),
                                    init_byte(1, 16'h81), init_byte(1, 16'h80)});

        // Randomized traffic on both instances
        for (int k = 0; k < 160; k++) begin
            int g;
            logic [31:0] a;
            g = $urandom_range(0, 1);
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC;
            txn(g, 1'($urandom_range(0, 1)), 3'($urandom), a, $urandom,
                $urandom_range(0, 3), rd, flt, lat, wes);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
